fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// - Fetch-stage pipeline register of the Aquila core. Sits between the PCU/I-memory port and Decode.
// - Consumes the pipeline controller's Fetch flush (flush2fet) and load-use stall (data_hazard).
// - Latches each returned instruction with its request PC and branch-hit tag.
// - Absorbs a response arriving during a stall (1-entry skid). Discards a response made stale by a flush.
// PARAMETERS
// - XLEN      32             data/address width
// - NOP_INSTR 32'h0000_0013  bubble instruction (addi x0,x0,0)
// PORTS
// - clk_i            in   1     core clock; one clock domain
// - rst_i            in   1     reset, synchronous, active-high
// - stall_i          in   1     load-use stall from pipeline control; hold outputs
// - flush_i          in   1     Fetch flush from pipeline control
// - fetch_req_i      in   1     PCU issued an I-memory request this cycle
// - pc_i             in   XLEN  PC of the request issued this cycle
// - pred_hit_i       in   1     BPU hit for the request issued this cycle
// - instr_i          in   XLEN  instruction returned by I-memory
// - instr_valid_i    in   1     instr_i valid this cycle
// - instr_o          out  XLEN  instruction to Decode (registered)
// - pc_o             out  XLEN  PC of instr_o (registered)
// - pred_hit_o       out  1     BPU hit tag of instr_o (registered)
// - valid_o          out  1     instr_o is a real instruction (registered)
// - fetch_stall_o    out  1     request outstanding, no response yet; stalls PCU (combinational)
// BEHAVIOUR
// - Reset: instr_o=NOP_INSTR, pc_o=0, pred_hit_o=0, valid_o=0, FSM=RUN, skid empty, outstanding=0.
//   Reset mid-operation drops every in-flight response.
// - Request tracking:
//   - outstanding is a 1-bit flag, set on fetch_req_i and cleared on instr_valid_i; set wins if both occur.
//   - pc_i and pred_hit_i are latched into req_pc/req_hit on fetch_req_i.
//   - fetch_req_i while outstanding=1 and instr_valid_i=0 is illegal (assert).
// - fetch_stall_o = outstanding & ~instr_valid_i & (state!=DISCARD). Driven low in DISCARD.
// - Priority per cycle: rst_i > flush_i > stall_i > normal.
// - FSM states: RUN, BUFFERED (skid holds one instr), DISCARD (next response is stale).
// - RUN, normal:
//   - instr_valid_i=1: next cycle instr_o=instr_i, pc_o=req_pc, pred_hit_o=req_hit, valid_o=1. Latency 1 cycle.
//   - instr_valid_i=0: next cycle instr_o=NOP_INSTR, valid_o=0 (bubble); pc_o is held.
// - RUN, stall_i=1:
//   - All outputs hold.
//   - instr_valid_i=1: capture {instr_i, req_pc, req_hit} into the skid and go to BUFFERED.
// - BUFFERED, stall_i=1:
//   - Outputs and skid hold.
//   - instr_valid_i=1 is illegal (PCU is stalled; assert).
// - BUFFERED, stall_i=0: next cycle outputs load from the skid with valid_o=1; skid empties; go to RUN.
// - Flush, from any state:
//   - Next cycle instr_o=NOP_INSTR, valid_o=0; skid is cleared.
//   - If outstanding=1 and instr_valid_i=0, go to DISCARD; otherwise go to RUN.
//   - A response arriving in the flush cycle is dropped.
//   - A fetch_req_i in the flush cycle is the redirected request and is still tracked; in that case go to RUN.
// - DISCARD:
//   - The first instr_valid_i is dropped (outputs stay bubble) and the FSM goes to RUN.
//   - flush_i in DISCARD stays in DISCARD.
//   - stall_i does not affect DISCARD.
// - flush_i and stall_i together: flush wins.
// TESTING
// 1) Reset then pc 0x0000_0000 req; instr_valid_i=1 with 0x0010_0093 next cycle -> following cycle
//    instr_o=0x0010_0093, pc_o=0x0, valid_o=1.
// 2) Req pc 0x104; stall_i=1 as instr 0x0020_0113 returns; hold 3 cycles -> outputs unchanged, state BUFFERED;
//    release -> next cycle instr_o=0x0020_0113, pc_o=0x104.
// 3) Req pc 0x108 outstanding, flush_i=1 with no response -> valid_o=0, instr_o=0x13; stale response next cycle dropped;
//    subsequent req pc 0x200 with 0x0030_0193 -> pc_o=0x200, valid_o=1.
// 4) flush_i and stall_i asserted together while BUFFERED -> skid cleared, valid_o=0, FSM RUN.
// 5) No instr_valid_i for 4 cycles with outstanding=1 -> fetch_stall_o=1 each cycle, valid_o=0;
//    response -> fetch_stall_o=0 that cycle.
// 6) rst_i asserted in BUFFERED -> next cycle all outputs at reset values; response after reset ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch-stage pipeline register: latches I-memory responses with their request PC and
// branch-hit tag, absorbs one response during a load-use stall and drops flushed responses.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            fetch_req_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pred_hit_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic            instr_valid_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_hit_o,
  output logic            valid_o,
  output logic            fetch_stall_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUFFERED = 2'd1,
    DISCARD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic            outstanding;
  logic [XLEN-1:0] req_pc_p0;
  logic            req_hit_p0;

  // Skid occupancy is implied by state==BUFFERED, so no separate valid flag is kept.
  logic [XLEN-1:0] skid_instr_p0;
  logic [XLEN-1:0] skid_pc_p0;
  logic            skid_hit_p0;

  logic [XLEN-1:0] instr_p1;
  logic [XLEN-1:0] pc_p1;
  logic            hit_p1;
  logic            vld_p1;

  logic resp;
  logic load_resp;
  logic load_skid;
  logic load_bubble;
  logic capture_skid;

  // A response only counts while a request is tracked; this also drops responses after reset.
  assign resp = instr_valid_i & outstanding;

  assign fetch_stall_o = outstanding & ~instr_valid_i & (state != DISCARD);

  always_comb begin
    state_nxt    = state;
    load_resp    = 1'b0;
    load_skid    = 1'b0;
    load_bubble  = 1'b0;
    capture_skid = 1'b0;
    if (flush_i) begin
      load_bubble = 1'b1;
      if (fetch_req_i) begin
        state_nxt = RUN;
      end else if (outstanding && !instr_valid_i) begin
        state_nxt = DISCARD;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      case (state)
        RUN: begin
          if (stall_i) begin
            if (resp) begin
              capture_skid = 1'b1;
              state_nxt    = BUFFERED;
            end
          end else if (resp) begin
            load_resp = 1'b1;
          end else begin
            load_bubble = 1'b1;
          end
        end
        BUFFERED: begin
          if (!stall_i) begin
            load_skid = 1'b1;
            state_nxt = RUN;
          end
        end
        DISCARD: begin
          load_bubble = 1'b1;
          if (resp) begin
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      outstanding <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fetch_req_i) begin
        outstanding <= 1'b1;
      end else if (instr_valid_i) begin
        outstanding <= 1'b0;
      end
    end
  end

  // p0: request tag and skid capture
  always_ff @(posedge clk_i) begin
    if (fetch_req_i) begin
      req_pc_p0  <= pc_i;
      req_hit_p0 <= pred_hit_i;
    end
    if (capture_skid) begin
      skid_instr_p0 <= instr_i;
      skid_pc_p0    <= req_pc_p0;
      skid_hit_p0   <= req_hit_p0;
    end
  end

  // p1: registered Decode-facing outputs; bubbles keep the last PC and its hit tag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_p1 <= NOP_INSTR;
      pc_p1    <= '0;
      hit_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (load_resp) begin
      instr_p1 <= instr_i;
      pc_p1    <= req_pc_p0;
      hit_p1   <= req_hit_p0;
      vld_p1   <= 1'b1;
    end else if (load_skid) begin
      instr_p1 <= skid_instr_p0;
      pc_p1    <= skid_pc_p0;
      hit_p1   <= skid_hit_p0;
      vld_p1   <= 1'b1;
    end else if (load_bubble) begin
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end
  end

  assign instr_o    = instr_p1;
  assign pc_o       = pc_p1;
  assign pred_hit_o = hit_p1;
  assign valid_o    = vld_p1;

  a_req_while_busy : assert property (@(posedge clk_i) disable iff (rst_i)
    !(fetch_req_i && outstanding && !instr_valid_i));

  a_resp_while_buffered : assert property (@(posedge clk_i) disable iff (rst_i)
    !(state == BUFFERED && stall_i && !flush_i && instr_valid_i));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: each record drives one cycle of inputs and
// gives the expected fetch_stall_o before the edge and the registered outputs after it.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        fetch_req_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pred_hit_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        pred_hit_o;
  logic        valid_o;
  logic        fetch_stall_o;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .fetch_req_i  (fetch_req_i),
    .pc_i         (pc_i),
    .pred_hit_i   (pred_hit_i),
    .instr_i      (instr_i),
    .instr_valid_i(instr_valid_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .pred_hit_o   (pred_hit_o),
    .valid_o      (valid_o),
    .fetch_stall_o(fetch_stall_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        req;
    logic [31:0] pc;
    logic        hit;
    logic [31:0] instr;
    logic        ivld;
    logic        e_fstall;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_hit;
    logic        e_vld;
  } vec_t;

  function automatic vec_t mk(logic rst, logic stall, logic flush, logic req,
                              logic [31:0] pc, logic hit, logic [31:0] instr, logic ivld,
                              logic e_fstall, logic [31:0] e_instr, logic [31:0] e_pc,
                              logic e_hit, logic e_vld);
    vec_t v;
    v.rst = rst; v.stall = stall; v.flush = flush; v.req = req;
    v.pc = pc; v.hit = hit; v.instr = instr; v.ivld = ivld;
    v.e_fstall = e_fstall; v.e_instr = e_instr; v.e_pc = e_pc;
    v.e_hit = e_hit; v.e_vld = e_vld;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst_i = v.rst; stall_i = v.stall; flush_i = v.flush; fetch_req_i = v.req;
    pc_i = v.pc; pred_hit_i = v.hit; instr_i = v.instr; instr_valid_i = v.ivld;
    #1;
    if (!v.rst) chk("fetch_stall", idx, {31'b0, fetch_stall_o}, {31'b0, v.e_fstall});
    @(posedge clk);
    #1;
    chk("instr", idx, instr_o, v.e_instr);
    chk("pc", idx, pc_o, v.e_pc);
    chk("pred_hit", idx, {31'b0, pred_hit_o}, {31'b0, v.e_hit});
    chk("valid", idx, {31'b0, valid_o}, {31'b0, v.e_vld});
  endtask

  vec_t vecs[$];

  initial begin
    // basic fetch, latency 1
    vecs.push_back(mk(0,0,0,1,32'h0,  0,32'h0,        0, 0, NOP,          32'h0,  0,0));
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0010_0093,1, 0, 32'h0010_0093,32'h0,  0,1));
    // response during stall goes to skid, held 3 cycles, then released
    vecs.push_back(mk(0,0,0,1,32'h104,1,32'h0,        0, 0, NOP,          32'h0,  0,0));
    vecs.push_back(mk(0,1,0,0,32'h0,  0,32'h0020_0113,1, 0, NOP,          32'h0,  0,0));
    vecs.push_back(mk(0,1,0,0,32'h0,  0,32'h0,        0, 0, NOP,          32'h0,  0,0));
    vecs.push_back(mk(0,1,0,0,32'h0,  0,32'h0,        0, 0, NOP,          32'h0,  0,0));
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        0, 0, 32'h0020_0113,32'h104,1,1));
    // flush with outstanding request, stale response dropped
    vecs.push_back(mk(0,0,0,1,32'h108,0,32'h0,        0, 0, NOP,          32'h104,1,0));
    vecs.push_back(mk(0,0,1,0,32'h0,  0,32'h0,        0, 1, NOP,          32'h104,1,0));
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        0, 0, NOP,          32'h104,1,0));
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'hdead_beef,1, 0, NOP,          32'h104,1,0));
    vecs.push_back(mk(0,0,0,1,32'h200,0,32'h0,        0, 0, NOP,          32'h104,1,0));
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0030_0193,1, 0, 32'h0030_0193,32'h200,0,1));
    // flush and stall together while BUFFERED
    vecs.push_back(mk(0,0,0,1,32'h300,1,32'h0,        0, 0, NOP,          32'h200,0,0));
    vecs.push_back(mk(0,1,0,0,32'h0,  0,32'h0040_0213,1, 0, NOP,          32'h200,0,0));
    vecs.push_back(mk(0,1,1,0,32'h0,  0,32'h0,        0, 0, NOP,          32'h200,0,0));
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        0, 0, NOP,          32'h200,0,0));
    // long memory latency keeps fetch_stall_o high
    vecs.push_back(mk(0,0,0,1,32'h400,0,32'h0,        0, 0, NOP,          32'h200,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,0,0,32'h0,0,32'h0,        0, 1, NOP,          32'h200,0,0));
    vecs.push_back(mk(0,0,0,1,32'h404,1,32'h0050_0293,1, 0, 32'h0050_0293,32'h400,0,1));
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0060_0313,1, 0, 32'h0060_0313,32'h404,1,1));
    vecs.push_back(mk(0,1,0,0,32'h0,  0,32'h0,        0, 0, 32'h0060_0313,32'h404,1,1));
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        0, 0, NOP,          32'h404,1,0));
    // response in flush cycle dropped; redirected request in flush cycle tracked
    vecs.push_back(mk(0,0,0,1,32'h500,0,32'h0,        0, 0, NOP,          32'h404,1,0));
    vecs.push_back(mk(0,0,1,0,32'h0,  0,32'h1111_1111,1, 0, NOP,          32'h404,1,0));
    vecs.push_back(mk(0,0,1,1,32'h600,1,32'h0,        0, 0, NOP,          32'h404,1,0));
    vecs.push_back(mk(0,0,0,0,32'h0,  0,32'h0090_0493,1, 0, 32'h0090_0493,32'h600,1,1));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_instr", 0, instr_o, NOP);
    chk("reset_pc", 0, pc_o, 32'h0);
    chk("reset_hit", 0, {31'b0, pred_hit_o}, 32'h0);
    chk("reset_valid", 0, {31'b0, valid_o}, 32'h0);
    chk("reset_fetch_stall", 0, {31'b0, fetch_stall_o}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    // reset while BUFFERED: skid and in-flight state are lost
    apply(mk(0,0,0,1,32'h700,0,32'h0,        0, 0, NOP,32'h600,1,0), 101);
    apply(mk(0,1,0,0,32'h0,  0,32'h00a0_0513,1, 0, NOP,32'h600,1,0), 102);
    apply(mk(0,1,0,0,32'h0,  0,32'h0,        0, 0, NOP,32'h600,1,0), 103);
    apply(mk(1,1,0,0,32'h0,  0,32'h0,        0, 0, NOP,32'h0,  0,0), 104);
    apply(mk(0,0,0,0,32'h0,  0,32'h00b0_0593,1, 0, NOP,32'h0,  0,0), 105);
    apply(mk(0,0,0,0,32'h0,  0,32'h0,        0, 0, NOP,32'h0,  0,0), 106);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
